// File: rtl/ws2812_rx_decoder.sv
// WS2812 NRZ receiver: classifies high-pulse widths into bits, assembles GRB words and frames.
// Optional cascaded-pixel forwarding on DOUT is enabled by defining WS2812_RX_FWD_EN.
`timescale 1ns/1ps
module ws2812_rx_decoder #(
  parameter int LED_NUM   = 16,
  parameter int ADDR_BIT  = $clog2(LED_NUM) + 1,
  parameter int THRESH    = 62,
  parameter int MIN_HIGH  = 15,
  parameter int MAX_HIGH  = 150,
  parameter int RESET_CYC = 5000
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                DIN,
  output logic [23:0]         GRB_OUT,
  output logic [23:0]         RGB_OUT,
  output logic                WVALID,
  output logic [ADDR_BIT-1:0] WNT,
  output logic                FRAME_END,
  output logic                BUSY,
  output logic                ERR,
  output logic [1:0]          ERR_CODE,
  output logic                DOUT
);

  typedef enum logic [1:0] {S_SYNC, S_IDLE, S_HIGH, S_LOW} state_t;

  localparam logic [15:0]         THRESH_C = 16'(THRESH);
  localparam logic [15:0]         MIN_C    = 16'(MIN_HIGH);
  localparam logic [15:0]         MAX_C    = 16'(MAX_HIGH);
  localparam logic [15:0]         RESET_C  = 16'(RESET_CYC);
  localparam logic [ADDR_BIT-1:0] LED_C    = ADDR_BIT'(LED_NUM);

  state_t              state_q, state_d;
  logic                sync1_q, sync2_q, prev_q;
  logic [15:0]         delay_q, delay_d;
  logic [23:0]         shift_q, shift_d;
  logic [4:0]          bitcnt_q, bitcnt_d;
  logic [ADDR_BIT-1:0] wnt_q, wnt_d;
  logic [23:0]         grb_q, grb_d, rgb_q, rgb_d;
  logic                wvalid_q, wvalid_d, fe_q, fe_d, busy_q, busy_d;
  logic                err_q, err_d, dout_q, dout_d;
  logic [1:0]          code_q, code_d;
  logic                rise_s, fall_s, bit_s;
  logic [23:0]         word_s;
`ifdef WS2812_RX_FWD_EN
  logic                fwd_q, fwd_d;
`endif

  assign rise_s = sync2_q & ~prev_q;
  assign fall_s = ~sync2_q & prev_q;
  assign bit_s  = (delay_q >= THRESH_C);
  assign word_s = {shift_q[22:0], bit_s};

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      prev_q   <= 1'b0;
      state_q  <= S_SYNC;
      delay_q  <= 16'd0;
      shift_q  <= 24'd0;
      bitcnt_q <= 5'd0;
      wnt_q    <= '0;
      grb_q    <= 24'd0;
      rgb_q    <= 24'd0;
      wvalid_q <= 1'b0;
      fe_q     <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      code_q   <= 2'd0;
      dout_q   <= 1'b0;
`ifdef WS2812_RX_FWD_EN
      fwd_q    <= 1'b0;
`endif
    end else begin
      sync1_q  <= DIN;
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q;
      state_q  <= state_d;
      delay_q  <= delay_d;
      shift_q  <= shift_d;
      bitcnt_q <= bitcnt_d;
      wnt_q    <= wnt_d;
      grb_q    <= grb_d;
      rgb_q    <= rgb_d;
      wvalid_q <= wvalid_d;
      fe_q     <= fe_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
      code_q   <= code_d;
      dout_q   <= dout_d;
`ifdef WS2812_RX_FWD_EN
      fwd_q    <= fwd_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bitcnt_d = bitcnt_q;
    wnt_d    = wnt_q;
    grb_d    = grb_q;
    rgb_d    = rgb_q;
    wvalid_d = 1'b0;
    fe_d     = 1'b0;
    busy_d   = busy_q;
    err_d    = 1'b0;
    code_d   = code_q;
    dout_d   = 1'b0;

    if (rise_s || fall_s) begin
      delay_d = 16'd0;
    end else if (delay_q != 16'hFFFF) begin
      delay_d = delay_q + 16'd1;
    end else begin
      delay_d = delay_q;
    end

    // The index advances while its strobe is on the outputs.
    if (wvalid_q) begin
      wnt_d = wnt_q + ADDR_BIT'(1);
    end else begin
      wnt_d = wnt_q;
    end

    case (state_q)
      S_SYNC: begin
        busy_d = 1'b0;
        if (!rise_s && !sync2_q && delay_q >= RESET_C) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_SYNC;
        end
      end
      S_IDLE: begin
        if (rise_s) begin
          busy_d  = 1'b1;
          state_d = S_HIGH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HIGH: begin
        if (delay_q > MAX_C || (fall_s && delay_q < MIN_C)) begin
          err_d    = 1'b1;
          code_d   = (delay_q > MAX_C) ? 2'd2 : 2'd1;
          busy_d   = 1'b0;
          bitcnt_d = 5'd0;
          shift_d  = 24'd0;
          wnt_d    = '0;
          state_d  = S_SYNC;
        end else if (fall_s) begin
          shift_d = word_s;
          state_d = S_LOW;
          if (bitcnt_q == 5'd23) begin
            bitcnt_d = 5'd0;
            if (wnt_q < LED_C) begin
              wvalid_d = 1'b1;
              grb_d    = word_s;
              rgb_d    = {word_s[15:8], word_s[23:16], word_s[7:0]};
            end else begin
`ifndef WS2812_RX_FWD_EN
              err_d  = 1'b1;
              code_d = 2'd3;
`endif
            end
          end else begin
            bitcnt_d = bitcnt_q + 5'd1;
          end
        end else begin
          state_d = S_HIGH;
        end
      end
      S_LOW: begin
        if (rise_s) begin
          state_d = S_HIGH;
        end else if (delay_q == RESET_C) begin
          // A gap with a partial word still closes the frame, but flags it.
          fe_d     = 1'b1;
          busy_d   = 1'b0;
          wnt_d    = '0;
          bitcnt_d = 5'd0;
          shift_d  = 24'd0;
          state_d  = S_IDLE;
          if (bitcnt_q != 5'd0) begin
            err_d  = 1'b1;
            code_d = 2'd3;
          end else begin
            err_d  = 1'b0;
          end
        end else begin
          state_d = S_LOW;
        end
      end
      default: begin
        state_d = S_SYNC;
      end
    endcase

`ifdef WS2812_RX_FWD_EN
    fwd_d = fwd_q;
    if (fe_d || state_d == S_SYNC) begin
      fwd_d = 1'b0;
    end else if (wvalid_q && wnt_q == '0) begin
      fwd_d = 1'b1;
    end else begin
      fwd_d = fwd_q;
    end
    dout_d = fwd_q & sync2_q;
`else
    dout_d = 1'b0;
`endif
  end

  assign GRB_OUT   = grb_q;
  assign RGB_OUT   = rgb_q;
  assign WVALID    = wvalid_q;
  assign WNT       = wnt_q;
  assign FRAME_END = fe_q;
  assign BUSY      = busy_q;
  assign ERR       = err_q;
  assign ERR_CODE  = code_q;
  assign DOUT      = dout_q;

endmodule

// File: tb/tb_ws2812_rx_decoder.sv
// Directed bench for ws2812_rx_decoder: one 16-word instance and one LED_NUM=2 instance share the line.
`timescale 1ns/1ps
module tb_ws2812_rx_decoder;
  logic        CLK, RST, DIN;
  logic [23:0] grb, rgb, grb2, rgb2;
  logic        wv, fe, busy, err, dout, wv2, fe2, busy2, err2, dout2;
  logic [4:0]  wnt;
  logic [1:0]  wnt2, code, code2;

  ws2812_rx_decoder dut (
    .CLK(CLK), .RST(RST), .DIN(DIN), .GRB_OUT(grb), .RGB_OUT(rgb), .WVALID(wv), .WNT(wnt),
    .FRAME_END(fe), .BUSY(busy), .ERR(err), .ERR_CODE(code), .DOUT(dout));

  ws2812_rx_decoder #(.LED_NUM(2)) dut2 (
    .CLK(CLK), .RST(RST), .DIN(DIN), .GRB_OUT(grb2), .RGB_OUT(rgb2), .WVALID(wv2), .WNT(wnt2),
    .FRAME_END(fe2), .BUSY(busy2), .ERR(err2), .ERR_CODE(code2), .DOUT(dout2));

  int errors = 0;
  int checks = 0;
  int wv_cnt = 0, fe_cnt = 0, err_cnt = 0, both_cnt = 0, wv2_cnt = 0, err2_cnt = 0;
  logic dout_hi = 1'b0, dout2_hi = 1'b0;
  logic [23:0] grb_log [0:63];
  logic [23:0] rgb_log [0:63];
  logic [4:0]  wnt_log [0:63];
  logic [1:0]  wnt2_log [0:63];
  int b_wv, b_fe, b_err, b_both, b_wv2, b_err2;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Strobe recorder, sampled mid-cycle.
  always @(negedge CLK) begin
    if (wv) begin
      grb_log[wv_cnt[5:0]] = grb;
      rgb_log[wv_cnt[5:0]] = rgb;
      wnt_log[wv_cnt[5:0]] = wnt;
      wv_cnt = wv_cnt + 1;
    end
    if (wv2) begin
      wnt2_log[wv2_cnt[5:0]] = wnt2;
      wv2_cnt = wv2_cnt + 1;
    end
    if (fe) fe_cnt = fe_cnt + 1;
    if (err) err_cnt = err_cnt + 1;
    if (err && fe) both_cnt = both_cnt + 1;
    if (err2) err2_cnt = err2_cnt + 1;
    if (dout) dout_hi = 1'b1;
    if (dout2) dout2_hi = 1'b1;
  end

  initial begin
    #1_500_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_low(input int n);
    DIN = 1'b0;
    repeat (n) @(negedge CLK);
  endtask

  task automatic send_bit(input logic b);
    DIN = 1'b1;
    repeat (b ? 90 : 35) @(negedge CLK);
    DIN = 1'b0;
    repeat (b ? 35 : 90) @(negedge CLK);
  endtask

  task automatic send_word(input logic [23:0] w);
    for (int i = 23; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic snap();
    b_wv = wv_cnt; b_fe = fe_cnt; b_err = err_cnt; b_both = both_cnt;
    b_wv2 = wv2_cnt; b_err2 = err2_cnt;
  endtask

  initial begin
    logic [23:0] w6;
    RST = 1'b1;
    DIN = 1'b0;
    repeat (4) @(negedge CLK);
    check("rst_grb", {8'd0, grb}, 32'd0);
    check("rst_rgb", {8'd0, rgb}, 32'd0);
    check("rst_strobes", {28'd0, wv, fe, err, busy}, 32'd0);
    check("rst_wnt_code", {25'd0, wnt, code}, 32'd0);
    check("rst_dout", {31'd0, dout}, 32'd0);
    RST = 1'b0;

    // Test 1: single word
    wait_low(6000);
    snap();
    send_word(24'hA53CF0);
    check("t1_busy", {31'd0, busy}, 32'd1);
    wait_low(6000);
    check("t1_wv_cnt", wv_cnt - b_wv, 1);
    check("t1_grb", {8'd0, grb_log[b_wv]}, 32'h00A53CF0);
    check("t1_rgb", {8'd0, rgb_log[b_wv]}, 32'h003CA5F0);
    check("t1_wnt", {27'd0, wnt_log[b_wv]}, 32'd0);
    check("t1_fe_cnt", fe_cnt - b_fe, 1);
    check("t1_err_cnt", err_cnt - b_err, 0);
    check("t1_busy_end", {31'd0, busy}, 32'd0);

    // Test 2: three words; the LED_NUM=2 instance overflows on the third
    snap();
    send_word(24'h000001);
    send_word(24'h800000);
    send_word(24'hFFFFFF);
    wait_low(6000);
    check("t2_wv_cnt", wv_cnt - b_wv, 3);
    check("t2_grb0", {8'd0, grb_log[b_wv]}, 32'h00000001);
    check("t2_grb1", {8'd0, grb_log[b_wv + 1]}, 32'h00800000);
    check("t2_grb2", {8'd0, grb_log[b_wv + 2]}, 32'h00FFFFFF);
    check("t2_rgb1", {8'd0, rgb_log[b_wv + 1]}, 32'h00008000);
    check("t2_wnt_seq", {17'd0, wnt_log[b_wv], wnt_log[b_wv + 1], wnt_log[b_wv + 2]},
          {17'd0, 5'd0, 5'd1, 5'd2});
    check("t2_fe_cnt", fe_cnt - b_fe, 1);
    check("t2_err_cnt", err_cnt - b_err, 0);
    check("t2_wnt_reset", {27'd0, wnt}, 32'd0);
    check("t5_wv2_cnt", wv2_cnt - b_wv2, 2);
    check("t5_wnt2_seq", {28'd0, wnt2_log[b_wv2], wnt2_log[b_wv2 + 1]}, {28'd0, 2'd0, 2'd1});
`ifdef WS2812_RX_FWD_EN
    check("t5_err2_cnt", err2_cnt - b_err2, 0);
    check("t5_dout2_fwd", {31'd0, dout2_hi}, 32'd1);
`else
    check("t5_err2_cnt", err2_cnt - b_err2, 1);
    check("t5_code2", {30'd0, code2}, 32'd3);
`endif

    // Test 3: partial frame of 10 bits
    snap();
    for (int i = 9; i >= 0; i--) send_bit(i[0]);
    wait_low(6000);
    check("t3_wv_cnt", wv_cnt - b_wv, 0);
    check("t3_err_cnt", err_cnt - b_err, 1);
    check("t3_code", {30'd0, code}, 32'd3);
    check("t3_err_with_fe", both_cnt - b_both, 1);
    check("t3_fe_cnt", fe_cnt - b_fe, 1);

    // Test 4: glitch mid-word, ignored bits, then a clean word
    snap();
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    DIN = 1'b1;
    repeat (8) @(negedge CLK);
    wait_low(90);
    check("t4_glitch_err", err_cnt - b_err, 1);
    check("t4_glitch_code", {30'd0, code}, 32'd1);
    check("t4_busy", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 10; i++) send_bit(1'b1);
    wait_low(6000);
    check("t4_ignored", (wv_cnt - b_wv) + (fe_cnt - b_fe), 0);
    send_word(24'h123456);
    wait_low(6000);
    check("t4_wv_cnt", wv_cnt - b_wv, 1);
    check("t4_grb", {8'd0, grb_log[b_wv]}, 32'h00123456);
    check("t4_wnt", {27'd0, wnt_log[b_wv]}, 32'd0);
    check("t4_fe_cnt", fe_cnt - b_fe, 1);
    check("t4_err_cnt", err_cnt - b_err, 1);

    // Test 6: reset during bit 12, then a clean frame
    w6 = 24'hC0FFEE;
    for (int i = 23; i >= 13; i--) send_bit(w6[i]);
    DIN = 1'b1;
    repeat (40) @(negedge CLK);
    snap();
    RST = 1'b1;
    DIN = 1'b0;
    repeat (4) @(negedge CLK);
    RST = 1'b0;
    check("t6_rst_state", {26'd0, busy, wnt}, 32'd0);
    for (int i = 11; i >= 0; i--) send_bit(w6[i]);
    wait_low(6000);
    check("t6_no_strobes", (wv_cnt - b_wv) + (fe_cnt - b_fe) + (err_cnt - b_err), 0);
    send_word(24'hC0FFEE);
    wait_low(6000);
    check("t6_wv_cnt", wv_cnt - b_wv, 1);
    check("t6_grb", {8'd0, grb_log[b_wv]}, 32'h00C0FFEE);
    check("t6_wnt", {27'd0, wnt_log[b_wv]}, 32'd0);
    check("t6_fe_cnt", fe_cnt - b_fe, 1);
    check("t6_err_cnt", err_cnt - b_err, 0);
`ifndef WS2812_RX_FWD_EN
    check("dout_tied_low", {30'd0, dout_hi, dout2_hi}, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
